regmux_read_arbiter: RTL and testbench

Round-robin read arbiter and burst sequencer that shares the single flat 64x16 register read mux among NUM_REQ requesters. Each requester asks for a burst of 1-4 consecutive registers. The block drives the mux index, captures the mux output into a registered response, and returns beats to the granted requester. It sits between the register bank and its consumers (ALU operand fetch, debug readout, DMA-style readers).

---
 rtl/regmux_pkg.sv | 20 ++
 rtl/regmux_read_arbiter_rr_pick.sv | 38 +++
 rtl/regmux_read_arbiter.sv | 161 ++++++++++++++++
 tb/tb_regmux_read_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/regmux_pkg.sv
// regmux_pkg
// Shared definitions for the register read-mux arbiter slice.
// Contents:
//   IDX_W_DEF / DATA_W_DEF / NUM_REGS_DEF : default register-bank geometry
//   regmux_state_t                         : arbiter FSM states
//   burst_len_t                            : burst length minus one (0..3)
package regmux_pkg;

    localparam int IDX_W_DEF    = 6;
    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 64;

    typedef enum logic {
        IDLE,
        BURST
    } regmux_state_t;

    typedef logic [1:0] burst_len_t;

endpackage

// File: rtl/regmux_read_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker: selects the first set bit of valid_i at
// or after position ptr_i, searching modulo N.
// Ports:
//   valid_i     in  N   request vector
//   ptr_i       in  PW  highest-priority position
//   grant_o     out N   one-hot grant (zero when nothing is valid)
//   grant_idx_o out PW  index of the granted position
//   any_valid_o out 1   at least one request is valid
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o,
    output logic          any_valid_o
);

    logic [PW-1:0] pos;

    // Scan from the farthest position back toward ptr_i so the nearest valid
    // requester is the last one written and therefore wins.
    always_comb begin
        grant_idx_o = '0;
        pos         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = PW'((int'(ptr_i) + k) % N);
            if (valid_i[pos]) begin
                grant_idx_o = pos;
            end
        end
        any_valid_o = |valid_i;
        grant_o     = any_valid_o ? (N'(1) << grant_idx_o) : '0;
    end

endmodule

// File: rtl/regmux_read_arbiter.sv
// regmux_read_arbiter
// Round-robin arbiter and burst sequencer sharing one register read mux among
// NUM_REQ requesters. Each accepted request reads 1-4 consecutive registers;
// every issued index produces one registered response beat a cycle later.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   req_valid    per-requester request, held until accepted
//   req_index    packed start indices, requester i at [i*IDX_W +: IDX_W]
//   req_len      packed burst length minus one, requester i at [i*2 +: 2]
//   req_ready    one-hot combinational accept strobe
//   mux_index    index driven to the register read mux
//   mux_data     combinational mux output
//   rsp_valid    registered one-hot beat valid
//   rsp_data     registered beat data (holds when no beat)
//   rsp_last     final beat of the burst
//   busy         burst in progress
module regmux_read_arbiter
    import regmux_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_index,
    input  logic [NUM_REQ*2-1:0]   req_len,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [IDX_W-1:0]       mux_index,
    input  logic [DATA_W-1:0]      mux_data,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_last,
    output logic                   busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    regmux_state_t      state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    burst_len_t         rem_q, rem_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_last_q, rsp_last_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   sel_index;
    burst_len_t         sel_len;

    logic               issue;
    logic               issue_last;
    logic [PTR_W-1:0]   issue_gnt;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .valid_i     (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (pick_onehot),
        .grant_idx_o (pick_idx),
        .any_valid_o (pick_any)
    );

    assign sel_index = req_index[pick_idx*IDX_W +: IDX_W];
    assign sel_len   = burst_len_t'(req_len[pick_idx*2 +: 2]);

    // Next-state and mux-drive logic. While rst_n is low nothing is issued so
    // the mux index and accept strobe stay quiet for the whole reset window.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        cur_d      = cur_q;
        rem_d      = rem_q;
        req_ready  = '0;
        mux_index  = '0;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_gnt  = gnt_q;

        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        req_ready  = pick_onehot;
                        mux_index  = sel_index;
                        rr_ptr_d   = PTR_W'((int'(pick_idx) + 1) % NUM_REQ);
                        gnt_d      = pick_idx;
                        cur_d      = sel_index + IDX_W'(1);
                        rem_d      = sel_len;
                        issue      = 1'b1;
                        issue_gnt  = pick_idx;
                        issue_last = (sel_len == 2'd0);
                        state_d    = (sel_len == 2'd0) ? IDLE : BURST;
                    end
                end
                BURST: begin
                    // cur wraps naturally at IDX_W bits (63 -> 0).
                    mux_index  = cur_q;
                    cur_d      = cur_q + IDX_W'(1);
                    rem_d      = rem_q - 2'd1;
                    issue      = 1'b1;
                    issue_last = (rem_q == 2'd1);
                    if (rem_q == 2'd1) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Response stage: a beat captures whatever the mux presents in its issue
    // cycle, so writes landing mid-burst are visible to later beats.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = 1'b0;
        if (issue) begin
            rsp_valid_d = NUM_REQ'(1) << issue_gnt;
            rsp_data_d  = mux_data;
            rsp_last_d  = issue_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            cur_q       <= '0;
            rem_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_regmux_read_arbiter.sv
// tb_regmux_read_arbiter
// Directed bench for regmux_read_arbiter with a behavioural 64x16 register
// bank feeding mux_data. Expected values are hand-computed from reg[i] = A000+i.
module tb_regmux_read_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 6;
    localparam int DATA_W  = 16;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_index;
    logic [NUM_REQ*2-1:0]     req_len;
    logic [NUM_REQ-1:0]       req_ready;
    logic [IDX_W-1:0]         mux_index;
    logic [DATA_W-1:0]        mux_data;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [DATA_W-1:0]        rsp_data;
    logic                     rsp_last;
    logic                     busy;

    logic [DATA_W-1:0] bank [64];

    int errors = 0;
    int checks = 0;

    regmux_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_index (req_index),
        .req_len   (req_len),
        .req_ready (req_ready),
        .mux_index (mux_index),
        .mux_data  (mux_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    assign mux_data = bank[mux_index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int r, input logic valid,
                                 input logic [IDX_W-1:0] idx, input logic [1:0] len);
        req_valid[r]              = valid;
        req_index[r*IDX_W +: IDX_W] = idx;
        req_len[r*2 +: 2]         = len;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRsp(input string tag, input logic [3:0] v,
                            input logic [15:0] d, input logic l);
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
        checkOutput({tag, ".rsp_data"},  32'(rsp_data),  32'(d));
        checkOutput({tag, ".rsp_last"},  32'(rsp_last),  32'(l));
    endtask

    task automatic checkIssue(input string tag, input logic [3:0] rdy,
                              input logic [5:0] idx, input logic bsy);
        checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
        checkOutput({tag, ".mux_index"}, 32'(mux_index), 32'(idx));
        checkOutput({tag, ".busy"},      32'(busy),      32'(bsy));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) bank[i] = 16'hA000 + 16'(i);
        rst_n     = 1'b0;
        req_valid = '0;
        req_index = '0;
        req_len   = '0;

        // Reset held three cycles with every requester asking.
        applyStimulus(0, 1'b1, 6'd10, 2'd0);
        applyStimulus(1, 1'b1, 6'd11, 2'd0);
        applyStimulus(2, 1'b1, 6'd12, 2'd0);
        applyStimulus(3, 1'b1, 6'd13, 2'd0);
        #1;
        checkOutput("rst_pre.req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_pre.mux_index", 32'(mux_index), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkIssue("rst", 4'b0000, 6'd0, 1'b0);
            checkRsp("rst", 4'b0000, 16'h0000, 1'b0);
        end

        // Release: first grant to 0, then round robin 1,2,3,0.
        rst_n = 1'b1;
        #1;
        checkIssue("rr0", 4'b0001, 6'd10, 1'b0);
        tick();
        checkRsp("rr1", 4'b0001, 16'hA00A, 1'b1);
        checkIssue("rr1", 4'b0010, 6'd11, 1'b0);
        tick();
        checkRsp("rr2", 4'b0010, 16'hA00B, 1'b1);
        checkIssue("rr2", 4'b0100, 6'd12, 1'b0);
        tick();
        checkRsp("rr3", 4'b0100, 16'hA00C, 1'b1);
        checkIssue("rr3", 4'b1000, 6'd13, 1'b0);
        tick();
        checkRsp("rr4", 4'b1000, 16'hA00D, 1'b1);
        checkIssue("rr4", 4'b0001, 6'd10, 1'b0);
        tick();
        req_valid = '0;
        #1;
        checkRsp("rr5", 4'b0001, 16'hA00A, 1'b1);
        checkIssue("idle", 4'b0000, 6'd0, 1'b0);
        tick();
        checkRsp("idle_hold", 4'b0000, 16'hA00A, 1'b0);

        // Single read: requester 2, index 5 (rr_ptr = 1).
        applyStimulus(2, 1'b1, 6'd5, 2'd0);
        #1;
        checkIssue("single", 4'b0100, 6'd5, 1'b0);
        tick();
        req_valid = '0;
        #1;
        checkRsp("single", 4'b0100, 16'hA005, 1'b1);

        // Burst wrap: requester 1 from 62, len 3 (rr_ptr = 3); requester 0
        // waits and must not be accepted until the burst has issued.
        applyStimulus(1, 1'b1, 6'd62, 2'd3);
        #1;
        checkIssue("wrap_T0", 4'b0010, 6'd62, 1'b0);
        tick();
        applyStimulus(1, 1'b0, 6'd62, 2'd3);
        applyStimulus(0, 1'b1, 6'd20, 2'd0);
        #1;
        checkRsp("wrap_T1", 4'b0010, 16'hA03E, 1'b0);
        checkIssue("wrap_T1", 4'b0000, 6'd63, 1'b1);
        tick();
        checkRsp("wrap_T2", 4'b0010, 16'hA03F, 1'b0);
        checkIssue("wrap_T2", 4'b0000, 6'd0, 1'b1);
        tick();
        checkRsp("wrap_T3", 4'b0010, 16'hA000, 1'b0);
        checkIssue("wrap_T3", 4'b0000, 6'd1, 1'b1);
        tick();
        checkRsp("wrap_T4", 4'b0010, 16'hA001, 1'b1);
        checkIssue("wrap_T4", 4'b0001, 6'd20, 1'b0);
        tick();
        req_valid = '0;
        #1;
        checkRsp("wrap_T5", 4'b0001, 16'hA014, 1'b1);

        // Contention: requester 2 moves rr_ptr to 3, then 3 bursts (len 1)
        // while 0 waits. A register write lands before the second beat issues.
        applyStimulus(2, 1'b1, 6'd7, 2'd0);
        #1;
        checkIssue("cont_pre", 4'b0100, 6'd7, 1'b0);
        tick();
        applyStimulus(2, 1'b0, 6'd7, 2'd0);
        applyStimulus(3, 1'b1, 6'd40, 2'd1);
        applyStimulus(0, 1'b1, 6'd50, 2'd0);
        #1;
        checkRsp("cont_pre", 4'b0100, 16'hA007, 1'b1);
        checkIssue("cont_T0", 4'b1000, 6'd40, 1'b0);
        tick();
        applyStimulus(3, 1'b0, 6'd40, 2'd1);
        bank[41] = 16'h1234;
        #1;
        checkRsp("cont_T1", 4'b1000, 16'hA028, 1'b0);
        checkIssue("cont_T1", 4'b0000, 6'd41, 1'b1);
        tick();
        checkRsp("cont_T2", 4'b1000, 16'h1234, 1'b1);
        checkIssue("cont_T2", 4'b0001, 6'd50, 1'b0);
        tick();
        req_valid = '0;
        #1;
        checkRsp("cont_T3", 4'b0001, 16'hA032, 1'b1);

        // Reset during beat 1 of a len-3 burst from requester 1 (rr_ptr = 1).
        applyStimulus(1, 1'b1, 6'd0, 2'd3);
        #1;
        checkIssue("mid_T0", 4'b0010, 6'd0, 1'b0);
        tick();
        req_valid = '0;
        #1;
        checkRsp("mid_T1", 4'b0010, 16'hA000, 1'b0);
        checkIssue("mid_T1", 4'b0000, 6'd1, 1'b1);
        tick();
        checkRsp("mid_T2", 4'b0010, 16'hA001, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst.req_ready", 32'(req_ready), 32'h0);
        checkOutput("mid_rst.mux_index", 32'(mux_index), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        checkRsp("mid_T3", 4'b0000, 16'h0000, 1'b0);
        checkIssue("mid_T3", 4'b0000, 6'd0, 1'b0);
        tick();
        checkRsp("mid_T4", 4'b0000, 16'h0000, 1'b0);

        // Fresh request after reset: rr_ptr back at 0, requester 3 len 1.
        applyStimulus(3, 1'b1, 6'd9, 2'd1);
        #1;
        checkIssue("post_T0", 4'b1000, 6'd9, 1'b0);
        tick();
        req_valid = '0;
        #1;
        checkRsp("post_T1", 4'b1000, 16'hA009, 1'b0);
        checkIssue("post_T1", 4'b0000, 6'd10, 1'b1);
        tick();
        checkRsp("post_T2", 4'b1000, 16'hA00A, 1'b1);
        checkOutput("post_T2.busy", 32'(busy), 32'h0);
        tick();
        checkRsp("post_T3", 4'b0000, 16'hA00A, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
